rv32i_dmem_responder: RTL and testbench

- Data-bus responder (slave end) for the core's daddress/dwrite/dread/dwaitrequest interface.
- Backs the bus with a byte-enabled single-port word RAM plus a memory-mapped 64-bit machine timer whose compare match drives the core's irq input.
- Sits beside the core in the top-level SoC, one instance per core data port.

---
 rtl/rv32i_dmem_responder_pkg.sv | 29 ++
 rtl/rv32i_dmem_timer.sv | 63 ++++++
 rtl/rv32i_dmem_responder.sv | 125 ++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared constants for the data-bus responder: FSM states, timer offsets.
// Also provides the byte-lane merge helper used by RAM and timer writes.
package rv32i_dmem_responder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32i_dmem_timer.sv
// 64-bit machine timer with compare register and registered level irq.
// Bus writes honour byte enables; a write to mtime beats the increment.
module rv32i_dmem_timer
  import rv32i_dmem_responder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q;

  // Next timer state: free-running count unless mtime is written
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    cmp_d   = cmp_q;
    if (we_i) begin
      case (sel_i)
        MTIME_LO: mtime_d = {mtime_q[63:32],
          be_merge(mtime_q[31:0], wdata_i, be_i)};
        MTIME_HI: mtime_d = {
          be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        MTIMECMP_LO: cmp_d = {cmp_q[63:32],
          be_merge(cmp_q[31:0], wdata_i, be_i)};
        default: cmp_d = {
          be_merge(cmp_q[63:32], wdata_i, be_i), cmp_q[31:0]};
      endcase
    end
  end

  // Register read mux for the timer window
  always_comb begin
    case (sel_i)
      MTIME_LO:    rdata_o = mtime_q[31:0];
      MTIME_HI:    rdata_o = mtime_q[63:32];
      MTIMECMP_LO: rdata_o = cmp_q[31:0];
      default:     rdata_o = cmp_q[63:32];
    endcase
  end

  // Timer registers and one-cycle-late compare result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= 64'd0;
      cmp_q   <= MTIMECMP_RST;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-bus responder: byte-enabled word RAM, fixed read wait states.
// Timer window and irq exist only when RV32I_DMEM_TIMER_EN is defined.
module rv32i_dmem_responder
  import rv32i_dmem_responder_pkg::*;
#(
  parameter int unsigned LOG2_MEM_WORDS   = 12,
  parameter logic [31:0] MEM_BASE         = 32'h0000_0000,
  parameter logic [31:0] TIMER_BASE       = 32'hAFFF_FFE0,
  parameter int unsigned READ_WAIT_STATES = 1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  output logic        irq
);

  localparam int unsigned MEM_WORDS = 1 << LOG2_MEM_WORDS;
  localparam logic [3:0]  CNT_INIT  = 4'(READ_WAIT_STATES - 1);

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] ram_off;
  logic        ram_hit;
  logic [LOG2_MEM_WORDS-1:0] ram_idx;
  logic        tmr_hit;
  logic [31:0] tmr_rdata;
  logic [31:0] rd_mux;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;

  logic unused_bits;

  assign ram_off = daddress - MEM_BASE;
  assign ram_hit = (ram_off >> (LOG2_MEM_WORDS + 2)) == 32'd0;
  assign ram_idx = ram_off[LOG2_MEM_WORDS+1:2];
  assign unused_bits = ^{ram_off[1:0], TIMER_BASE};

`ifdef RV32I_DMEM_TIMER_EN
  assign tmr_hit = (daddress[31:4] == TIMER_BASE[31:4]);

  rv32i_dmem_timer u_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (dwrite & tmr_hit),
    .sel_i   (daddress[3:2]),
    .wdata_i (dwritedata),
    .be_i    (dbyteenable),
    .rdata_o (tmr_rdata),
    .irq_o   (irq)
  );
`else
  assign tmr_hit   = 1'b0;
  assign tmr_rdata = 32'h0;
  assign irq       = 1'b0;
`endif

  // Zero-wait RAM write, per byte lane
  always_ff @(posedge clk) begin
    if (dwrite && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dbyteenable[b])
          mem[ram_idx][8*b +: 8] <= dwritedata[8*b +: 8];
      end
    end
  end

  // Select read source by address window; unmapped reads 0
  always_comb begin
    rd_mux = 32'h0;
    if (ram_hit)      rd_mux = mem[ram_idx];
    else if (tmr_hit) rd_mux = tmr_rdata;
  end

  // Read FSM: capture in IDLE, count stalls, present in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (dread) begin
          data_d  = rd_mux;
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!dread) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, stall counter and held read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign dwaitrequest = dread & (state_q != S_RESP);
  assign dreaddata    = data_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Randomized self-checking bench for rv32i_dmem_responder.
// Transaction-level reference model; RV32I_DMEM_TIMER_EN selects timer checks.
module tb_rv32i_dmem_responder;

  localparam int          RWS       = 3;
  localparam logic [31:0] TB        = 32'hAFFF_FFE0;
  localparam logic [31:0] MEM_BYTES = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddress;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic        dread;
  logic [31:0] dreaddata;
  logic        dwaitrequest;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ram_m [int];
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_irq;
  bit          mt_wr;
  int          mk;

  rv32i_dmem_responder #(
    .READ_WAIT_STATES (RWS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .daddress     (daddress),
    .dwrite       (dwrite),
    .dwritedata   (dwritedata),
    .dbyteenable  (dbyteenable),
    .dread        (dread),
    .dreaddata    (dreaddata),
    .dwaitrequest (dwaitrequest),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] n,
                                        logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic bit t_hit(logic [31:0] a);
    return a[31:4] == TB[31:4];
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (a < MEM_BYTES)
      return ram_m.exists(k) ? ram_m[k] : 32'hx;
`ifdef RV32I_DMEM_TIMER_EN
    if (t_hit(a)) begin
      case (a[3:2])
        2'd0:    return m_mtime[31:0];
        2'd1:    return m_mtime[63:32];
        2'd2:    return m_cmp[31:0];
        default: return m_cmp[63:32];
      endcase
    end
`endif
    return 32'h0;
  endfunction

  // Reference model: memory contents, timer and irq
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mtime = 64'd0;
      m_cmp   = '1;
      m_irq   = 1'b0;
    end else begin
      mt_wr = 1'b0;
`ifdef RV32I_DMEM_TIMER_EN
      m_irq = (m_mtime >= m_cmp);
`endif
      if (dwrite) begin
        if (daddress < MEM_BYTES) begin
          mk = int'(daddress >> 2);
          ram_m[mk] = merge(ram_m.exists(mk) ? ram_m[mk] : 32'hx,
                            dwritedata, dbyteenable);
        end
`ifdef RV32I_DMEM_TIMER_EN
        else if (t_hit(daddress)) begin
          case (daddress[3:2])
            2'd0: begin
              m_mtime[31:0] = merge(m_mtime[31:0], dwritedata,
                                    dbyteenable);
              mt_wr = 1'b1;
            end
            2'd1: begin
              m_mtime[63:32] = merge(m_mtime[63:32], dwritedata,
                                     dbyteenable);
              mt_wr = 1'b1;
            end
            2'd2: m_cmp[31:0] = merge(m_cmp[31:0], dwritedata,
                                      dbyteenable);
            default: m_cmp[63:32] = merge(m_cmp[63:32], dwritedata,
                                          dbyteenable);
          endcase
        end
`endif
      end
      if (!mt_wr) m_mtime = m_mtime + 64'd1;
    end
  end

  // Per-cycle compare: no stall without dread, irq matches model
  always @(negedge clk) begin
    if (!reset) begin
      if (!dread) check("no_stall", 64'(dwaitrequest), 64'd0);
      check("irq", 64'(irq), 64'(m_irq));
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    daddress    = a;
    dwritedata  = d;
    dbyteenable = be;
    dwrite      = 1'b1;
    @(posedge clk);
    #1;
    dwrite = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input logic [31:0] exp,
                           output logic [31:0] got);
    int st;
    bit done;
    st   = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (dwaitrequest) st++;
      else done = 1'b1;
      if (i == 0 && !done) begin
        @(posedge clk);
        #1;
        dwrite = 1'b0;
      end
    end
    check({nm, "_done"}, 64'(done), 64'd1);
    check({nm, "_stalls"}, 64'(st), 64'(RWS));
    got = dreaddata;
    check({nm, "_data"}, 64'(got), 64'(exp));
  endtask

  task automatic do_read(input logic [31:0] a, input bit hold,
                         input bit wr, input logic [31:0] wd,
                         output logic [31:0] got);
    logic [31:0] exp;
    daddress = a;
    dread    = 1'b1;
    exp      = model_read(a);
    if (wr) begin
      dwrite      = 1'b1;
      dwritedata  = wd;
      dbyteenable = 4'hF;
    end
    wait_resp("rd", exp, got);
    @(posedge clk);
    #1;
    if (!hold) dread = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4:
        r = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      5: r = 32'h40;
      6: r = 32'h100;
      7: r = 32'h3FFC;
      8: begin
        case ($urandom_range(0, 2))
          0:       r = 32'h8000_0000;
          1:       r = MEM_BYTES;
          default: r = TB + 32'h10;
        endcase
      end
      default: r = TB + 32'($urandom_range(0, 3)) * 4;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] g;
    logic [31:0] a;
    bit          seen;
    dread       = 1'b1;
    daddress    = 32'h0;
    dwrite      = 1'b0;
    dwritedata  = 32'h0;
    dbyteenable = 4'h0;
    #12;
    check("rst_wait_hi", 64'(dwaitrequest), 64'd1);
    check("rst_rdata", 64'(dreaddata), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    dread = 1'b0;
    #1;
    check("rst_wait_lo", 64'(dwaitrequest), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef RV32I_DMEM_TIMER_EN
    do_write(TB + 32'h8, 32'd20, 4'hF);
    do_write(TB + 32'hC, 32'd0, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = irq;
    end
    check("irq_rise_seen", 64'(seen), 64'd1);
    check("irq_rise_mtime", m_mtime, 64'd21);
    @(posedge clk);
    #1;
    do_write(TB + 32'hC, 32'd1, 4'hF);
    @(negedge clk);
    check("irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    check("irq_drop", 64'(irq), 64'd0);
    @(posedge clk);
    #1;
`else
    do_read(TB, 1'b0, 1'b0, 32'h0, g);
    check("tmr_unmapped", 64'(g), 64'd0);
    do_write(TB + 32'h8, 32'h0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check("irq_off", 64'(irq), 64'd0);
`endif

    for (int i = 0; i < 16; i++)
      do_write(32'(i) * 4, $urandom, 4'hF);
    do_write(32'h3FFC, $urandom, 4'hF);

    do_write(32'h100, 32'hDEADBEEF, 4'hF);
    do_read(32'h100, 1'b0, 1'b0, 32'h0, g);
    check("deadbeef", 64'(g), 64'hDEADBEEF);

    do_write(32'h40, 32'h11223344, 4'hF);
    do_write(32'h40, 32'hAABBCCDD, 4'b0101);
    do_read(32'h40, 1'b0, 1'b0, 32'h0, g);
    check("byte_lanes", 64'(g), 64'h11BB33DD);

    do_write(32'h0, 32'hCAFE0000, 4'hF);
    do_write(32'h4, 32'h0BADF00D, 4'hF);
    do_read(32'h0, 1'b1, 1'b0, 32'h0, g);
    check("b2b_first", 64'(g), 64'hCAFE0000);
    do_read(32'h4, 1'b0, 1'b0, 32'h0, g);
    check("b2b_second", 64'(g), 64'h0BADF00D);

    do_read(32'h8000_0000, 1'b0, 1'b0, 32'h0, g);
    check("unmapped_rd", 64'(g), 64'd0);
    do_write(32'h8000_0000, 32'h12345678, 4'hF);
    do_write(MEM_BYTES, 32'h87654321, 4'hF);
    do_read(32'h0, 1'b0, 1'b0, 32'h0, g);
    check("unmapped_wr", 64'(g), 64'hCAFE0000);

    do_write(32'h8, 32'h01020304, 4'hF);
    do_read(32'h8, 1'b0, 1'b1, 32'h5555AAAA, g);
    check("rw_same_old", 64'(g), 64'h01020304);
    do_read(32'h8, 1'b0, 1'b0, 32'h0, g);
    check("rw_same_new", 64'(g), 64'h5555AAAA);

    daddress = 32'h100;
    dread    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_wait", 64'(dwaitrequest), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_wait", 64'(dwaitrequest), 64'd1);
    check("rst_mid_data", 64'(dreaddata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_resp("rst_rd", model_read(32'h100), g);
    check("rst_rd_lit", 64'(g), 64'hDEADBEEF);
    @(posedge clk);
    #1;
    dread = 1'b0;

    for (int n = 0; n < 200; n++) begin
      a = pick_addr();
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)));
        1: do_read(a, 1'b0, 1'b0, 32'h0, g);
        default: do_read(a, 1'b0, 1'b1, $urandom, g);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
